// File: rtl/spi_block_sequencer.sv
// spi_block_sequencer: drives a byte-level SPI master through a block of
// NUM_BYTES bytes, MSB-first, collecting the returned bytes into rx_block.
// done/error are registered one-cycle pulses raised on the return to IDLE.
// byte_start is combinational from ISSUE so the gap between a byte_done and
// the next byte_start is exactly GAP_CYCLES idle cycles.
module spi_block_sequencer #(
  parameter int NUM_BYTES  = 16,
  parameter int GAP_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  input  logic [8*NUM_BYTES-1:0] tx_block,
  output logic [8*NUM_BYTES-1:0] rx_block,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic                   byte_start,
  output logic [7:0]             byte_data_in,
  input  logic [7:0]             byte_data_out,
  input  logic                   byte_busy,
  input  logic                   byte_done
);
  localparam int BW    = 8*NUM_BYTES;
  localparam int IDX_W = $clog2(NUM_BYTES+1);
  localparam int TO_W  = $clog2(TIMEOUT+1);
  localparam int GAP_W = $clog2(GAP_CYCLES+2);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DONE, GAP, FINISH} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     tx_sh_q, tx_sh_d;
  logic [BW-1:0]     rx_sh_q, rx_sh_d;
  logic [BW-1:0]     rx_blk_q, rx_blk_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign error        = error_q;
  assign rx_block     = rx_blk_q;
  assign byte_start   = (state_q == ISSUE) && !byte_busy;
  assign byte_data_in = tx_sh_q[BW-1 -: 8];

  // Next-state and datapath; abort takes priority in every non-IDLE state.
  always_comb begin
    state_d   = state_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_blk_d  = rx_blk_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // the cycle showing done is still IDLE; start there is dropped
        if (start && !done_q) begin
          tx_sh_d = tx_block;
          rx_sh_d = '0;
          idx_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) state_d = IDLE;
        else if (!byte_busy) begin
          tx_sh_d  = tx_sh_q << 8;
          to_cnt_d = '0;
          state_d  = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (abort) state_d = IDLE;
        else if (byte_done) begin
          rx_sh_d = (rx_sh_q << 8) | BW'(byte_data_out);
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_BYTES-1)) state_d = FINISH;
          else if (GAP_CYCLES == 0)         state_d = ISSUE;
          else begin
            gap_cnt_d = '0;
            state_d   = GAP;
          end
        end else if (to_cnt_q >= TO_W'(TIMEOUT-1)) begin
          error_d = 1'b1;
          state_d = IDLE;
        end else if (to_cnt_q != '1) begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      GAP: begin
        if (abort) state_d = IDLE;
        else if (gap_cnt_q >= GAP_W'(GAP_CYCLES-1)) state_d = ISSUE;
        else if (gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + GAP_W'(1);
      end
      FINISH: begin
        if (abort) state_d = IDLE;
        else begin
          rx_blk_d = rx_sh_q;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_blk_q  <= '0;
      idx_q     <= '0;
      to_cnt_q  <= '0;
      gap_cnt_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_blk_q  <= rx_blk_d;
      idx_q     <= idx_d;
      to_cnt_q  <= to_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end
endmodule
